fsm_cmd_arbiter: RTL and testbench

Round-robin command arbiter that shares one small command-driven FSM (3-bit command input, 2-bit state) among `N_REQ` requesters. It checks each granted command for legality and issues it as a one-cycle strobe. It holds the grant until the FSM signals completion or a timeout fires, and permanently locks out any requester that repeatedly issues illegal commands. It sits between the requester bus and the FSM's command port.

---
 rtl/fsm_cmd_arbiter_if.sv | 26 ++
 rtl/fsm_cmd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fsm_cmd_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_cmd_arbiter_if.sv
// Requester-side command bus: requests and commands in, grant/strobe/status out.
`timescale 1ns/1ps
interface fsm_cmd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CMD_W = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic                   cmd_done;
  logic [N_REQ-1:0]       gnt;
  logic                   cmd_valid;
  logic [CMD_W-1:0]       cmd_out;
  logic [N_REQ-1:0]       lockout;
  logic                   illegal_err;
  logic                   timeout_err;

  modport master (
    output req, req_cmd, cmd_done,
    input  gnt, cmd_valid, cmd_out, lockout, illegal_err, timeout_err
  );

  modport slave (
    input  req, req_cmd, cmd_done,
    output gnt, cmd_valid, cmd_out, lockout, illegal_err, timeout_err
  );
endinterface

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter feeding one command FSM: legality check, one-cycle issue strobe,
// grant held until done or timeout, sticky lockout of repeat offenders.
`timescale 1ns/1ps
module fsm_cmd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CMD_W     = 3,
  parameter int ERR_LIMIT = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  fsm_cmd_arbiter_if.slave s_bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] r_idx, w_idx_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [ERR_W-1:0] r_err_cnt     [N_REQ];
  logic [ERR_W-1:0] w_err_cnt_nxt [N_REQ];
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic [CMD_W-1:0] r_cmd_out, w_cmd_out_nxt;
  logic [N_REQ-1:0] r_lockout, w_lockout_nxt;
  logic             r_illegal_err, w_illegal_err_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;

  logic [N_REQ-1:0] w_elig;
  logic [PTR_W-1:0] w_sel;
  logic             w_found;
  logic [CMD_W-1:0] w_sel_cmd;
  logic             w_sel_legal;
  logic             w_timer_last;
  logic [ERR_W-1:0] w_err_inc;

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % N_REQ);
  endfunction

  function automatic logic [PTR_W-1:0] f_next_idx(input logic [PTR_W-1:0] idx);
    return f_wrap(idx, 1);
  endfunction

  function automatic logic f_is_legal(input logic [CMD_W-1:0] cmd);
    return (cmd != '0) && (cmd <= CMD_W'(3));
  endfunction

  function automatic logic [ERR_W-1:0] f_sat_inc(input logic [ERR_W-1:0] cnt);
    if (int'(cnt) >= ERR_LIMIT) return cnt;
    return cnt + ERR_W'(1);
  endfunction

  assign w_elig = s_bus.req & ~r_lockout;
  assign w_found = |w_elig;

  // Walk downward so the last hit is the one closest to the pointer.
  always_comb begin
    w_sel = r_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_elig[f_wrap(r_ptr, i)]) w_sel = f_wrap(r_ptr, i);
    end
  end

  assign w_sel_cmd    = CMD_W'(s_bus.req_cmd >> (int'(w_sel) * CMD_W));
  assign w_sel_legal  = f_is_legal(w_sel_cmd);
  assign w_timer_last = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_err_inc    = f_sat_inc(r_err_cnt[w_sel]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = (w_found && w_sel_legal) ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT: begin
        if (s_bus.cmd_done)    w_state_nxt = IDLE;
        else if (w_timer_last) w_state_nxt = ABORT;
        else                   w_state_nxt = WAIT;
      end
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; done beats a coincident timeout.
  always_comb begin
    w_ptr_nxt         = r_ptr;
    w_idx_nxt         = r_idx;
    w_timer_nxt       = r_timer;
    w_gnt_nxt         = r_gnt;
    w_cmd_valid_nxt   = 1'b0;
    w_cmd_out_nxt     = r_cmd_out;
    w_lockout_nxt     = r_lockout;
    w_illegal_err_nxt = 1'b0;
    w_timeout_err_nxt = 1'b0;
    for (int i = 0; i < N_REQ; i++) w_err_cnt_nxt[i] = r_err_cnt[i];

    case (r_state)
      IDLE: begin
        if (w_found) begin
          if (w_sel_legal) begin
            w_cmd_out_nxt    = w_sel_cmd;
            w_gnt_nxt        = '0;
            w_gnt_nxt[w_sel] = 1'b1;
            w_idx_nxt        = w_sel;
            w_cmd_valid_nxt  = 1'b1;
          end else begin
            w_illegal_err_nxt    = 1'b1;
            w_err_cnt_nxt[w_sel] = w_err_inc;
            if (int'(w_err_inc) == ERR_LIMIT) w_lockout_nxt[w_sel] = 1'b1;
            w_ptr_nxt = f_next_idx(w_sel);
          end
        end
      end
      ISSUE: w_timer_nxt = '0;
      WAIT: begin
        if (s_bus.cmd_done) begin
          w_gnt_nxt = '0;
          w_ptr_nxt = f_next_idx(r_idx);
        end else if (w_timer_last) begin
          w_gnt_nxt         = '0;
          w_ptr_nxt         = f_next_idx(r_idx);
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ABORT:   w_gnt_nxt = '0;
      default: w_gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_gnt         <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_out     <= '0;
      r_lockout     <= '0;
      r_illegal_err <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < N_REQ; i++) r_err_cnt[i] <= '0;
    end else begin
      r_ptr         <= w_ptr_nxt;
      r_idx         <= w_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_gnt         <= w_gnt_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_cmd_out     <= w_cmd_out_nxt;
      r_lockout     <= w_lockout_nxt;
      r_illegal_err <= w_illegal_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      for (int i = 0; i < N_REQ; i++) r_err_cnt[i] <= w_err_cnt_nxt[i];
    end
  end

  assign s_bus.gnt         = r_gnt;
  assign s_bus.cmd_valid   = r_cmd_valid;
  assign s_bus.cmd_out     = r_cmd_out;
  assign s_bus.lockout     = r_lockout;
  assign s_bus.illegal_err = r_illegal_err;
  assign s_bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant/illegal/timeout events and
// per-cycle grant/lockout/cmd_out; a separate monitor compares them against the arbiter.
`timescale 1ns/1ps
module tb_fsm_cmd_arbiter;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int EL = 3;
  localparam int TO = 15;
  localparam int VW = N * CW;

  typedef enum int {EV_GRANT, EV_ILLEGAL, EV_TIMEOUT} ev_kind_t;
  typedef struct { ev_kind_t kind; int idx; int cmd; int stamp; } ev_t;
  typedef struct { int stamp; logic [N-1:0] gnt; logic [N-1:0] lock; logic [CW-1:0] cmd_out; } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ev_t  ev_q[$];
  cyc_t cyc_q[$];

  logic [N-1:0]  m_lock;
  int            m_err [N];
  int            m_ptr, m_free, m_gnt_last, m_done_edge, m_issue_edge, m_owner;
  logic [CW-1:0] m_cmd_out;
  int            fixed_d = 0;

  fsm_cmd_arbiter_if #(.N_REQ(N), .CMD_W(CW)) bus ();

  fsm_cmd_arbiter #(.N_REQ(N), .CMD_W(CW), .ERR_LIMIT(EL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic int pick_d();
    int r;
    if (fixed_d > 0) return fixed_d;
    r = int'($urandom_range(0, 5));
    case (r)
      0:       return 1;
      1:       return TO - 1;
      2:       return TO;
      3:       return TO + 1;
      default: return int'($urandom_range(1, TO + 1));
    endcase
  endfunction

  function automatic logic [VW-1:0] all_cmd(input int c);
    logic [CW-1:0] cc;
    cc = CW'(c);
    return {N{cc}};
  endfunction

  function automatic logic [VW-1:0] put_cmd(input logic [VW-1:0] v, input int idx, input int c);
    logic [VW-1:0] m, cv;
    m  = VW'({CW{1'b1}}) << (idx * CW);
    cv = VW'(CW'(c)) << (idx * CW);
    return (v & ~m) | cv;
  endfunction

  function automatic int rand_cmd();
    int r;
    if ($urandom_range(0, 9) != 0) return int'($urandom_range(1, 3));
    r = int'($urandom_range(0, 4));
    return (r == 0) ? 0 : r + 3;
  endfunction

  // Reference model for one clock edge e: who is granted, for how long, and what it emits.
  task automatic model_step(input int e, input logic rv, input logic [N-1:0] reqv,
                            input logic [VW-1:0] cmdv, output logic done_v);
    logic [N-1:0]  elig, tmp;
    logic [VW-1:0] tmpc;
    int sel, c, d, pos;
    cyc_t cr;
    done_v = 1'b0;
    if (!rv) begin
      m_lock = '0;
      foreach (m_err[i]) m_err[i] = 0;
      m_ptr = 0; m_free = e + 1; m_gnt_last = -1; m_done_edge = -1; m_issue_edge = -1;
      m_owner = 0; m_cmd_out = '0;
      for (int k = ev_q.size() - 1; k >= 0; k--) if (ev_q[k].stamp >= e) ev_q.delete(k);
    end else begin
      if (e == m_done_edge)       done_v = 1'b1;
      else if (e == m_issue_edge) done_v = 1'($urandom_range(0, 1));
      elig = reqv & ~m_lock;
      if (e >= m_free && elig != '0) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          pos = (m_ptr + k) % N;
          tmp = elig >> pos;
          if (sel < 0 && tmp[0]) sel = pos;
        end
        tmpc = cmdv >> (sel * CW);
        c = int'(tmpc[CW-1:0]);
        if (c >= 1 && c <= 3) begin
          d = pick_d();
          m_owner = sel; m_cmd_out = CW'(c); m_issue_edge = e + 1; m_ptr = (sel + 1) % N;
          ev_q.push_back('{EV_GRANT, sel, c, e});
          if (d <= TO) begin
            m_done_edge = e + 1 + d; m_gnt_last = e + d; m_free = e + 2 + d;
          end else begin
            m_done_edge = -1; m_gnt_last = e + TO; m_free = e + 3 + TO;
            ev_q.push_back('{EV_TIMEOUT, sel, 0, e + 1 + TO});
          end
        end else begin
          if (m_err[sel] < EL) m_err[sel] = m_err[sel] + 1;
          if (m_err[sel] == EL) m_lock = m_lock | (N'(1) << sel);
          m_ptr = (sel + 1) % N;
          ev_q.push_back('{EV_ILLEGAL, sel, c, e});
        end
      end
    end
    cr.stamp   = e;
    cr.gnt     = (e <= m_gnt_last) ? (N'(1) << m_owner) : '0;
    cr.lock    = m_lock;
    cr.cmd_out = m_cmd_out;
    cyc_q.push_back(cr);
  endtask

  task automatic drive_cycle(input logic rv, input logic [N-1:0] reqv, input logic [VW-1:0] cmdv);
    logic dn;
    model_step(edge_n + 1, rv, reqv, cmdv, dn);
    rst_n        = rv;
    bus.req      = reqv;
    bus.req_cmd  = cmdv;
    bus.cmd_done = dn;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    int   n;
    logic exp_v, exp_i, exp_t;
    cyc_t cr;
    ev_t  ev;
    n = edge_n;
    while (cyc_q.size() > 0 && cyc_q[0].stamp < n) void'(cyc_q.pop_front());
    if (cyc_q.size() > 0 && cyc_q[0].stamp == n) begin
      cr = cyc_q.pop_front();
      chk("gnt",     32'(bus.gnt),     32'(cr.gnt));
      chk("lockout", 32'(bus.lockout), 32'(cr.lock));
      chk("cmd_out", 32'(bus.cmd_out), 32'(cr.cmd_out));
    end
    exp_v = 1'b0; exp_i = 1'b0; exp_t = 1'b0;
    if (ev_q.size() > 0 && ev_q[0].stamp <= n) begin
      ev = ev_q.pop_front();
      if (ev.stamp == n) begin
        exp_v = (ev.kind == EV_GRANT);
        exp_i = (ev.kind == EV_ILLEGAL);
        exp_t = (ev.kind == EV_TIMEOUT);
        if (exp_v) chk("grant_cmd", 32'(bus.cmd_out), 32'(ev.cmd));
      end
    end
    chk("cmd_valid",   32'(bus.cmd_valid),   32'(exp_v));
    chk("illegal_err", 32'(bus.illegal_err), 32'(exp_i));
    chk("timeout_err", 32'(bus.timeout_err), 32'(exp_t));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] cv;
    logic [N-1:0]  rq;
    rst_n = 1'b0; bus.req = '0; bus.req_cmd = '0; bus.cmd_done = 1'b0;

    // Reset with everyone requesting, then round-robin with done one cycle into WAIT.
    fixed_d = 1;
    cv = all_cmd(2);
    repeat (2)  drive_cycle(1'b0, 4'b1111, cv);
    repeat (20) drive_cycle(1'b1, 4'b1111, cv);

    // Requester 1 keeps issuing cmd 0 until locked; requester 2 still served after.
    drive_cycle(1'b0, '0, '0);
    cv = put_cmd(all_cmd(2), 1, 0);
    repeat (6) drive_cycle(1'b1, 4'b0010, cv);
    cv = put_cmd(cv, 2, 3);
    repeat (8) drive_cycle(1'b1, 4'b0110, cv);

    // Full timeout, then done landing on the last WAIT cycle.
    drive_cycle(1'b0, '0, '0);
    fixed_d = TO + 1;
    drive_cycle(1'b1, 4'b0001, all_cmd(1));
    repeat (TO + 4) drive_cycle(1'b1, '0, all_cmd(1));
    fixed_d = TO;
    drive_cycle(1'b1, 4'b0001, all_cmd(1));
    repeat (TO + 4) drive_cycle(1'b1, '0, all_cmd(1));

    // Reset during WAIT clears grant and the partial error count of requester 3.
    drive_cycle(1'b0, '0, '0);
    fixed_d = TO + 1;
    cv = put_cmd(all_cmd(1), 3, 0);
    repeat (2) drive_cycle(1'b1, 4'b1000, cv);
    drive_cycle(1'b1, 4'b0001, cv);
    repeat (4) drive_cycle(1'b1, '0, cv);
    drive_cycle(1'b0, 4'b0001, cv);
    repeat (5) drive_cycle(1'b1, 4'b1000, cv);
    repeat (3) drive_cycle(1'b1, '0, cv);

    // Randomized traffic with occasional resets.
    fixed_d = 0;
    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom_range(0, (1 << N) - 1));
      cv = '0;
      for (int k = 0; k < N; k++) cv = put_cmd(cv, k, rand_cmd());
      if (i % 400 == 0 || $urandom_range(0, 199) == 0) drive_cycle(1'b0, rq, cv);
      else                                               drive_cycle(1'b1, rq, cv);
    end

    fixed_d = 1;
    repeat (TO + 5) drive_cycle(1'b1, '0, '0);
    @(negedge clk);
    #1;
    chk("events_drained", 32'(ev_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
